multicycle_ctrl_alu: RTL and testbench
======================================

MULTICYCLE_CTRL_ALU -- requirements
Module: multicycle_ctrl_alu

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port instr, input, 32 bits: current instruction; opcode is instr[31:26], funct is instr[5:0].
REQ-004 SHALL have ports srcA and srcB, input, 32 bits each: ALU operands, already selected by the datapath muxes.
REQ-005 SHALL have ports adderIn1 and adderIn2, input, 32 bits each: operands of the independent adder.
REQ-006 SHALL have port adderOut, output, 32 bits: sum of the two adder operands.
REQ-007 SHALL have ports ALUResult, output, 32 bits, and aluZero, output, 1 bit: ALU result and its zero flag.
REQ-008 SHALL have port ALUControl, output, 5 bits, plus alu4..alu0, output, 1 bit each, mirroring ALUControl[4:0].
REQ-009 SHALL have 1-bit outputs memToReg, memWrite, branchEnable, regDst, regWriteEnable, jump, jumpReg, PCWrite, IorD, IRWrite, ALUSrcA and pcEn.
REQ-010 SHALL have port ALUSrcB, output, 2 bits: 00 register B, 01 constant 4, 10 SignImm, 11 SignImm<<2.

Function
REQ-011 adderOut SHALL be combinational, adderIn1+adderIn2 mod 2^32, with the carry-out dropped.
REQ-012 ALU SHALL be combinational on srcA, srcB and ALUControl, using these codes:
- 00000 AND; 00001 OR; 00010 ADD; 00011 XOR; 00100 NOR;
- 00110 SUB (mod 2^32); 00111 SLT (signed, result 1 or 0);
- any other code gives 0.
REQ-013 aluZero SHALL be 1 exactly when ALUResult == 0.
REQ-014 Control SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, JAL, JR.
REQ-015 Transitions SHALL be:
- FETCH->DECODE.
- DECODE by opcode: 0x23 or 0x2B -> MEMADR; 0x00 with funct 0x08 -> JR; 0x00 with funct 0x20/0x22/0x24/0x25/0x26/0x27/0x2A -> EXECUTE; 0x04 -> BRANCH; 0x08 -> ADDIEXEC; 0x02 -> JUMP; 0x03 -> JAL.
- DECODE, any other opcode or funct: -> FETCH (treated as NOP).
- MEMADR -> MEMREAD for lw, MEMWRITE for sw.
- MEMREAD->MEMWB; EXECUTE->ALUWB; ADDIEXEC->ADDIWB.
- MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH, JUMP, JAL, JR -> FETCH.
REQ-016 Per-state outputs SHALL be as below; unlisted 1-bit outputs are 0, ALUSrcB is 00 and ALUControl is ADD (00010):
- FETCH: IorD=0, IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01.
- DECODE: ALUSrcA=0, ALUSrcB=11.
- MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10.
- MEMREAD: IorD=1.
- MEMWB: regWriteEnable=1, memToReg=1, regDst=0.
- MEMWRITE: IorD=1, memWrite=1.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from funct (0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT).
- ALUWB: regWriteEnable=1, regDst=1.
- ADDIWB: regWriteEnable=1, regDst=0.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=SUB, branchEnable=1.
- JUMP: jump=1, PCWrite=1.
- JAL: jump=1, PCWrite=1, regWriteEnable=1.
- JR: jumpReg=1, PCWrite=1.
REQ-017 pcEn SHALL be combinational, PCWrite OR (branchEnable AND aluZero).
REQ-018 Instruction latencies SHALL be: lw 5 cycles; sw, R-type and addi 4; beq, j, jal and jr 3; NOP 2.
REQ-019 instr SHALL be sampled only in DECODE and MEMADR; changes in other states SHALL have no effect on the path taken.

Reset
REQ-020 While reset is high, state SHALL be FETCH and PCWrite, IRWrite, memWrite, regWriteEnable and pcEn SHALL be forced to 0; the other outputs SHALL follow FETCH decode.
REQ-021 Reset asserted mid-instruction SHALL abort it immediately; the first rising edge after release SHALL execute FETCH.

Verification
REQ-022 Reset in DECODE -> all write enables 0 at once; after release: IRWrite=1, PCWrite=1, ALUControl=00010, ALUSrcB=01.
REQ-023 instr=0x8C080004 (lw) -> state order FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regWriteEnable=1 and memToReg=1 only in cycle 5.
REQ-024 instr=0x01095022 (sub) -> EXECUTE with ALUControl=00110; srcA=5, srcB=7 gives ALUResult=0xFFFFFFFE, aluZero=0; ALUWB with regDst=1.
REQ-025 instr=0x11090003 (beq), BRANCH state:
- srcA=srcB=0x1234 -> aluZero=1, pcEn=1.
- srcB=0x1235 -> pcEn=0.
REQ-026 SLT with srcA=0x80000000, srcB=1 -> ALUResult=1; adderIn1=0xFFFFFFFF, adderIn2=1 -> adderOut=0.
REQ-027 instr=0x08000010 (j) -> FETCH, DECODE, JUMP with jump=1 and PCWrite=1, then FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_alu_if.sv
// Bus bundle between the multicycle datapath and its controller/ALU block.
// The slave modport is the controller's view; the master modport is the datapath's.
interface multicycle_ctrl_alu_if;
  logic [31:0] instr;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [31:0] adderIn1;
  logic [31:0] adderIn2;
  logic [31:0] adderOut;
  logic [31:0] ALUResult;
  logic        aluZero;
  logic [4:0]  ALUControl;
  logic        alu4;
  logic        alu3;
  logic        alu2;
  logic        alu1;
  logic        alu0;
  logic        memToReg;
  logic        memWrite;
  logic        branchEnable;
  logic        regDst;
  logic        regWriteEnable;
  logic        jump;
  logic        jumpReg;
  logic        PCWrite;
  logic        IorD;
  logic        IRWrite;
  logic        ALUSrcA;
  logic        pcEn;
  logic [1:0]  ALUSrcB;

  modport slave (
    input  instr, srcA, srcB, adderIn1, adderIn2,
    output adderOut, ALUResult, aluZero, ALUControl,
           alu4, alu3, alu2, alu1, alu0,
           memToReg, memWrite, branchEnable, regDst, regWriteEnable,
           jump, jumpReg, PCWrite, IorD, IRWrite, ALUSrcA, pcEn, ALUSrcB
  );

  modport master (
    output instr, srcA, srcB, adderIn1, adderIn2,
    input  adderOut, ALUResult, aluZero, ALUControl,
           alu4, alu3, alu2, alu1, alu0,
           memToReg, memWrite, branchEnable, regDst, regWriteEnable,
           jump, jumpReg, PCWrite, IorD, IRWrite, ALUSrcA, pcEn, ALUSrcB
  );
endinterface

// File: rtl/multicycle_ctrl_alu.sv
// Multicycle MIPS-subset controller (Moore FSM) with its ALU and the independent PC adder.
// Write enables are held low while reset is asserted.
module multicycle_ctrl_alu (
  input  logic                  clock,
  input  logic                  reset,
  multicycle_ctrl_alu_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_t;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_XOR = 5'b00011;
  localparam logic [4:0] ALU_NOR = 5'b00100;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  function automatic logic [4:0] funct_to_alu(input logic [5:0] f);
    logic [4:0] code;
    case (f)
      6'h20:   code = ALU_ADD;
      6'h22:   code = ALU_SUB;
      6'h24:   code = ALU_AND;
      6'h25:   code = ALU_OR;
      6'h26:   code = ALU_XOR;
      6'h27:   code = ALU_NOR;
      6'h2A:   code = ALU_SLT;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  function automatic logic is_alu_funct(input logic [5:0] f);
    logic ok;
    case (f)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: ok = 1'b1;
      default:                                         ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_funct;
  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic        w_unused;

  logic        w_mem_to_reg, w_mem_write, w_branch_en, w_reg_dst, w_reg_we;
  logic        w_jump, w_jump_reg, w_pc_write, w_iord, w_ir_write, w_alu_src_a;
  logic [1:0]  w_alu_src_b;
  logic [4:0]  w_alu_ctrl;
  logic [31:0] w_alu_result;
  logic        w_zero;

  assign w_opcode = bus.instr[31:26];
  assign w_funct  = bus.instr[5:0];
  assign w_unused = ^bus.instr[25:6];

  // State register; reset always lands on FETCH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Funct is captured in DECODE so EXECUTE is immune to later instr changes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_funct <= 6'd0;
    end else if (r_state == S_DECODE) begin
      r_funct <= w_funct;
    end else begin
      r_funct <= r_funct;
    end
  end

  // Next-state and Moore control decode.
  always_comb begin
    w_next       = S_FETCH;
    w_mem_to_reg = 1'b0;
    w_mem_write  = 1'b0;
    w_branch_en  = 1'b0;
    w_reg_dst    = 1'b0;
    w_reg_we     = 1'b0;
    w_jump       = 1'b0;
    w_jump_reg   = 1'b0;
    w_pc_write   = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_ctrl   = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_ir_write  = 1'b1;
        w_pc_write  = 1'b1;
        w_alu_src_b = 2'b01;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        case (w_opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE: begin
            if (w_funct == FN_JR) begin
              w_next = S_JR;
            end else if (is_alu_funct(w_funct)) begin
              w_next = S_EXECUTE;
            end else begin
              w_next = S_FETCH;
            end
          end
          OP_BEQ:  w_next = S_BRANCH;
          OP_ADDI: w_next = S_ADDIEXEC;
          OP_J:    w_next = S_JUMP;
          OP_JAL:  w_next = S_JAL;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = (w_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_reg_we     = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTE: begin
        w_alu_src_a = 1'b1;
        w_alu_ctrl  = funct_to_alu(r_funct);
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_we  = 1'b1;
        w_reg_dst = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_ctrl  = ALU_SUB;
        w_branch_en = 1'b1;
      end
      S_ADDIEXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_we = 1'b1;
      end
      S_JUMP: begin
        w_jump     = 1'b1;
        w_pc_write = 1'b1;
      end
      S_JAL: begin
        w_jump     = 1'b1;
        w_pc_write = 1'b1;
        w_reg_we   = 1'b1;
      end
      S_JR: begin
        w_jump_reg = 1'b1;
        w_pc_write = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // ALU datapath.
  always_comb begin
    w_alu_result = 32'd0;
    case (w_alu_ctrl)
      ALU_AND: w_alu_result = bus.srcA & bus.srcB;
      ALU_OR:  w_alu_result = bus.srcA | bus.srcB;
      ALU_ADD: w_alu_result = bus.srcA + bus.srcB;
      ALU_XOR: w_alu_result = bus.srcA ^ bus.srcB;
      ALU_NOR: w_alu_result = ~(bus.srcA | bus.srcB);
      ALU_SUB: w_alu_result = bus.srcA - bus.srcB;
      ALU_SLT: w_alu_result = {31'd0, ($signed(bus.srcA) < $signed(bus.srcB))};
      default: w_alu_result = 32'd0;
    endcase
  end

  assign w_zero        = (w_alu_result == 32'd0);
  assign bus.ALUResult = w_alu_result;
  assign bus.aluZero   = w_zero;
  assign bus.adderOut  = bus.adderIn1 + bus.adderIn2;

  assign bus.ALUControl = w_alu_ctrl;
  assign bus.alu4       = w_alu_ctrl[4];
  assign bus.alu3       = w_alu_ctrl[3];
  assign bus.alu2       = w_alu_ctrl[2];
  assign bus.alu1       = w_alu_ctrl[1];
  assign bus.alu0       = w_alu_ctrl[0];

  // Architectural write enables are masked by reset, independent of the clock.
  assign bus.PCWrite        = w_pc_write  & ~reset;
  assign bus.IRWrite        = w_ir_write  & ~reset;
  assign bus.memWrite       = w_mem_write & ~reset;
  assign bus.regWriteEnable = w_reg_we    & ~reset;
  assign bus.pcEn           = ~reset & (w_pc_write | (w_branch_en & w_zero));

  assign bus.memToReg     = w_mem_to_reg;
  assign bus.branchEnable = w_branch_en;
  assign bus.regDst       = w_reg_dst;
  assign bus.jump         = w_jump;
  assign bus.jumpReg      = w_jump_reg;
  assign bus.IorD         = w_iord;
  assign bus.ALUSrcA      = w_alu_src_a;
  assign bus.ALUSrcB      = w_alu_src_b;

endmodule

// File: tb/tb_multicycle_ctrl_alu.sv
// Directed bench for multicycle_ctrl_alu: expected values are queued when stimulus
// is applied and popped when the corresponding output is sampled on the falling edge.
module tb_multicycle_ctrl_alu;

  localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMREAD = 3, T_MEMWB = 4;
  localparam int T_MEMWRITE = 5, T_EXECUTE = 6, T_ALUWB = 7, T_BRANCH = 8, T_ADDIEXEC = 9;
  localparam int T_ADDIWB = 10, T_JUMP = 11, T_JAL = 12, T_JR = 13, T_RST = 14;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  sb_t  sb_q[$];

  multicycle_ctrl_alu_if bus ();

  multicycle_ctrl_alu dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] exp_alu(input logic [5:0] f);
    case (f)
      6'h20:   return 5'b00010;
      6'h22:   return 5'b00110;
      6'h24:   return 5'b00000;
      6'h25:   return 5'b00001;
      6'h26:   return 5'b00011;
      6'h27:   return 5'b00100;
      6'h2A:   return 5'b00111;
      default: return 5'b11111;
    endcase
  endfunction

  // {IorD,IRWrite,PCWrite,ALUSrcA,ALUSrcB,memToReg,memWrite,branchEnable,regDst,regWE,jump,jumpReg,ALUControl,alu4..0}
  function automatic logic [31:0] ctrl_exp(input int s, input logic [5:0] f);
    logic iord, irw, pcw, asa, m2r, mw, be, rd, rwe, j, jr;
    logic [1:0] asb;
    logic [4:0] ac;
    {iord, irw, pcw, asa, m2r, mw, be, rd, rwe, j, jr} = 11'd0;
    asb = 2'b00;
    ac  = 5'b00010;
    case (s)
      T_FETCH:    begin irw = 1'b1; pcw = 1'b1; asb = 2'b01; end
      T_RST:      begin asb = 2'b01; end
      T_DECODE:   begin asb = 2'b11; end
      T_MEMADR,
      T_ADDIEXEC: begin asa = 1'b1; asb = 2'b10; end
      T_MEMREAD:  begin iord = 1'b1; end
      T_MEMWB:    begin rwe = 1'b1; m2r = 1'b1; end
      T_MEMWRITE: begin iord = 1'b1; mw = 1'b1; end
      T_EXECUTE:  begin asa = 1'b1; ac = exp_alu(f); end
      T_ALUWB:    begin rwe = 1'b1; rd = 1'b1; end
      T_ADDIWB:   begin rwe = 1'b1; end
      T_BRANCH:   begin asa = 1'b1; ac = 5'b00110; be = 1'b1; end
      T_JUMP:     begin j = 1'b1; pcw = 1'b1; end
      T_JAL:      begin j = 1'b1; pcw = 1'b1; rwe = 1'b1; end
      T_JR:       begin jr = 1'b1; pcw = 1'b1; end
      default:    begin ac = 5'b11111; end
    endcase
    return {9'd0, iord, irw, pcw, asa, asb, m2r, mw, be, rd, rwe, j, jr, ac, ac};
  endfunction

  function automatic logic [31:0] ctrl_obs();
    return {9'd0, bus.IorD, bus.IRWrite, bus.PCWrite, bus.ALUSrcA, bus.ALUSrcB,
            bus.memToReg, bus.memWrite, bus.branchEnable, bus.regDst, bus.regWriteEnable,
            bus.jump, bus.jumpReg, bus.ALUControl,
            bus.alu4, bus.alu3, bus.alu2, bus.alu1, bus.alu0};
  endfunction

  task automatic push(input string tag, input logic [31:0] e);
    sb_t it;
    it.tag = tag;
    it.exp = e;
    sb_q.push_back(it);
  endtask

  task automatic cmp(input logic [31:0] obs);
    sb_t it;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h, no expected value queued", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance one cycle and check the full control vector of the state now entered.
  task automatic step(input string tag, input int s, input logic [5:0] f);
    push(tag, ctrl_exp(s, f));
    tick();
    cmp(ctrl_obs());
  endtask

  initial begin
    logic [5:0]  fn_tab [5];
    logic [31:0] a, b, r;

    fn_tab[0] = 6'h20; fn_tab[1] = 6'h24; fn_tab[2] = 6'h25;
    fn_tab[3] = 6'h26; fn_tab[4] = 6'h27;

    rst = 1'b1;
    bus.instr = 32'd0; bus.srcA = 32'd0; bus.srcB = 32'd0;
    bus.adderIn1 = 32'hFFFF_FFFF; bus.adderIn2 = 32'd1;
    @(negedge clk);

    push("reset_ctrl", ctrl_exp(T_RST, 6'd0)); cmp(ctrl_obs());
    push("reset_pcen", 32'd0);                 cmp({31'd0, bus.pcEn});
    push("adder_wrap", 32'd0);                 cmp(bus.adderOut);
    bus.adderIn1 = 32'h1234_5678; bus.adderIn2 = 32'h1111_1111; #1;
    push("adder_sum", 32'h2345_6789);          cmp(bus.adderOut);

    rst = 1'b0; #1;
    push("fetch_ctrl", ctrl_exp(T_FETCH, 6'd0)); cmp(ctrl_obs());
    push("fetch_pcen", 32'd1);                   cmp({31'd0, bus.pcEn});
    bus.srcA = 32'h10; bus.srcB = 32'h4; #1;
    push("fetch_add", 32'h14);                   cmp(bus.ALUResult);

    // lw; instr is scrambled after MEMADR to prove it is no longer consulted
    bus.instr = 32'h8C08_0004;
    step("lw_decode", T_DECODE, 6'd0);
    step("lw_memadr", T_MEMADR, 6'd0);
    step("lw_memread", T_MEMREAD, 6'd0);
    bus.instr = 32'hAC08_0004;
    step("lw_memwb", T_MEMWB, 6'd0);
    step("lw_fetch", T_FETCH, 6'd0);

    bus.instr = 32'hAC08_0004;
    step("sw_decode", T_DECODE, 6'd0);
    step("sw_memadr", T_MEMADR, 6'd0);
    step("sw_memwrite", T_MEMWRITE, 6'd0);
    step("sw_fetch", T_FETCH, 6'd0);

    bus.instr = 32'h0109_5022;
    step("sub_decode", T_DECODE, 6'd0);
    step("sub_execute", T_EXECUTE, 6'h22);
    bus.srcA = 32'd5; bus.srcB = 32'd7; #1;
    push("sub_result", 32'hFFFF_FFFE); cmp(bus.ALUResult);
    push("sub_zero", 32'd0);           cmp({31'd0, bus.aluZero});
    bus.instr = 32'h0000_0024; #1;
    push("sub_funct_held", 32'b00110); cmp({27'd0, bus.ALUControl});
    step("sub_aluwb", T_ALUWB, 6'd0);
    step("sub_fetch", T_FETCH, 6'd0);

    bus.instr = 32'h1109_0003;
    step("beq_decode", T_DECODE, 6'd0);
    step("beq_branch", T_BRANCH, 6'd0);
    bus.srcA = 32'h1234; bus.srcB = 32'h1234; #1;
    push("beq_zero", 32'd1); cmp({31'd0, bus.aluZero});
    push("beq_taken", 32'd1); cmp({31'd0, bus.pcEn});
    bus.srcB = 32'h1235; #1;
    push("beq_not_taken", 32'd0); cmp({31'd0, bus.pcEn});
    step("beq_fetch", T_FETCH, 6'd0);

    bus.instr = 32'h0109_502A;
    step("slt_decode", T_DECODE, 6'd0);
    step("slt_execute", T_EXECUTE, 6'h2A);
    bus.srcA = 32'h8000_0000; bus.srcB = 32'd1; #1;
    push("slt_neg_lt", 32'd1); cmp(bus.ALUResult);
    bus.srcA = 32'd1; bus.srcB = 32'h8000_0000; #1;
    push("slt_pos_ge", 32'd0); cmp(bus.ALUResult);
    step("slt_aluwb", T_ALUWB, 6'd0);
    step("slt_fetch", T_FETCH, 6'd0);

    a = 32'hF0F0_1234; b = 32'h0FF0_4321;
    for (int i = 0; i < 5; i++) begin
      bus.instr = {26'h0000_149, fn_tab[i]};
      step("rop_decode", T_DECODE, 6'd0);
      step("rop_execute", T_EXECUTE, fn_tab[i]);
      bus.srcA = a; bus.srcB = b; #1;
      case (fn_tab[i])
        6'h20:   r = a + b;
        6'h24:   r = a & b;
        6'h25:   r = a | b;
        6'h26:   r = a ^ b;
        default: r = ~(a | b);
      endcase
      push("rop_result", r); cmp(bus.ALUResult);
      step("rop_aluwb", T_ALUWB, 6'd0);
      step("rop_fetch", T_FETCH, 6'd0);
    end

    bus.instr = 32'h2108_0005;
    step("addi_decode", T_DECODE, 6'd0);
    step("addi_exec", T_ADDIEXEC, 6'd0);
    step("addi_wb", T_ADDIWB, 6'd0);
    step("addi_fetch", T_FETCH, 6'd0);

    bus.instr = 32'h0800_0010;
    step("j_decode", T_DECODE, 6'd0);
    step("j_jump", T_JUMP, 6'd0);
    push("j_pcen", 32'd1); cmp({31'd0, bus.pcEn});
    step("j_fetch", T_FETCH, 6'd0);

    bus.instr = 32'h0C00_0010;
    step("jal_decode", T_DECODE, 6'd0);
    step("jal_jal", T_JAL, 6'd0);
    step("jal_fetch", T_FETCH, 6'd0);

    bus.instr = 32'h0100_0008;
    step("jr_decode", T_DECODE, 6'd0);
    step("jr_jr", T_JR, 6'd0);
    step("jr_fetch", T_FETCH, 6'd0);

    bus.instr = 32'hFC00_0000;
    step("nop_decode", T_DECODE, 6'd0);
    step("nop_fetch", T_FETCH, 6'd0);
    bus.instr = 32'h0000_0003;
    step("badfn_decode", T_DECODE, 6'd0);
    step("badfn_fetch", T_FETCH, 6'd0);

    // reset while in DECODE of a lw
    bus.instr = 32'h8C08_0004;
    step("rstmid_decode", T_DECODE, 6'd0);
    rst = 1'b1; #1;
    push("rstmid_ctrl", ctrl_exp(T_RST, 6'd0)); cmp(ctrl_obs());
    push("rstmid_pcen", 32'd0);                 cmp({31'd0, bus.pcEn});
    step("rstmid_hold", T_RST, 6'd0);
    rst = 1'b0; #1;
    push("rstmid_release", ctrl_exp(T_FETCH, 6'd0)); cmp(ctrl_obs());
    step("rstmid_decode2", T_DECODE, 6'd0);
    step("rstmid_memadr", T_MEMADR, 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
